// File: rtl/control_fsm.sv
// Instruction sequencer for the exp6 LC-3b-style data path: fetch / decode / execute of ADD, AND, NOT, BR, JMP, PAUSE.
// Optional single-step mode is built when SINGLE_STEP_EN is defined (adds STEP1/STEP2 after every execute/NOP).
//
// state   | meaning
// --------+-------------------------------------------------------
// HALT  0 | idle, waiting for Run
// CLR   1 | PC <= 0
// FETCH1 2| MAR <= PC, PC <= PC+1; Run=0 here returns to HALT
// FETCH2 3| SRAM read, held MEM_WAIT cycles, load_mdr on the last
// FETCH3 4| IR <= MDR
// DECODE 5| dispatch on opcode
// EX_ADD 6| Rd <= Rs1 + (Rs2 | imm5)
// EX_AND 7| Rd <= Rs1 & (Rs2 | imm5)
// EX_NOT 8| Rd <= ~Rs1
// EX_BR  9| PC <= branch target when BEN
// EX_JMP 10| PC <= BaseR
// PAUSE1 11| wait for Continue high
// PAUSE2 12| wait for Continue low
// STEP1 14| single-step hold until Continue high (Run=0 -> HALT)
// STEP2 15| single-step hold until Continue low
module control_fsm #(
  parameter int         MEM_WAIT  = 2,
  parameter logic [3:0] PAUSE_OPC = 4'b1101
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] opcode,
  input  logic       imm5_sel,
  input  logic       BEN,
  output logic       load_ir,
  output logic       load_pc,
  output logic       load_mdr,
  output logic       load_mar,
  output logic       ld_reg,
  output logic [1:0] pc_sel,
  output logic [1:0] ALUK,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       SR2_mux_sel,
  output logic       Mem_CE,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] S_HALT   = 4'd0;
  localparam logic [3:0] S_CLR    = 4'd1;
  localparam logic [3:0] S_FETCH1 = 4'd2;
  localparam logic [3:0] S_FETCH2 = 4'd3;
  localparam logic [3:0] S_FETCH3 = 4'd4;
  localparam logic [3:0] S_DECODE = 4'd5;
  localparam logic [3:0] S_EX_ADD = 4'd6;
  localparam logic [3:0] S_EX_AND = 4'd7;
  localparam logic [3:0] S_EX_NOT = 4'd8;
  localparam logic [3:0] S_EX_BR  = 4'd9;
  localparam logic [3:0] S_EX_JMP = 4'd10;
  localparam logic [3:0] S_PAUSE1 = 4'd11;
  localparam logic [3:0] S_PAUSE2 = 4'd12;
`ifdef SINGLE_STEP_EN
  localparam logic [3:0] S_STEP1  = 4'd14;
  localparam logic [3:0] S_STEP2  = 4'd15;
  localparam logic [3:0] S_DONE   = S_STEP1;
`else
  localparam logic [3:0] S_DONE   = S_FETCH1;
`endif

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_HALT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_HALT:   if (Run) state_d = S_CLR;
      S_CLR:    state_d = S_FETCH1;
      S_FETCH1: begin
        cnt_d   = '0;
        state_d = Run ? S_FETCH2 : S_HALT;
      end
      S_FETCH2: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LAST) state_d = S_FETCH3;
      end
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'b0001: state_d = S_EX_ADD;
          4'b0101: state_d = S_EX_AND;
          4'b1001: state_d = S_EX_NOT;
          4'b0000: state_d = S_EX_BR;
          4'b1100: state_d = S_EX_JMP;
          default: state_d = (opcode == PAUSE_OPC) ? S_PAUSE1 : S_DONE;
        endcase
      end
      S_EX_ADD, S_EX_AND, S_EX_NOT, S_EX_BR, S_EX_JMP: state_d = S_DONE;
      S_PAUSE1: if (Continue) state_d = S_PAUSE2;
      S_PAUSE2: if (!Continue) state_d = S_FETCH1;
`ifdef SINGLE_STEP_EN
      S_STEP1: begin
        if (!Run) state_d = S_HALT;
        else if (Continue) state_d = S_STEP2;
      end
      S_STEP2:  if (!Continue) state_d = S_FETCH1;
`endif
      default:  state_d = S_HALT;
    endcase
  end

  // Moore decode; only SR2_mux_sel and the BR PC load look at live inputs.
  always_comb begin
    load_ir     = 1'b0;
    load_pc     = 1'b0;
    load_mdr    = 1'b0;
    load_mar    = 1'b0;
    ld_reg      = 1'b0;
    pc_sel      = 2'b00;
    ALUK        = 2'b00;
    GatePC      = 1'b0;
    GateMDR     = 1'b0;
    GateALU     = 1'b0;
    SR2_mux_sel = 1'b0;
    Mem_CE      = 1'b1;
    Mem_OE      = 1'b1;
    Mem_WE      = 1'b1;
    case (state_q)
      S_CLR: begin
        pc_sel  = 2'b11;
        load_pc = 1'b1;
      end
      S_FETCH1: begin
        GatePC   = 1'b1;
        load_mar = 1'b1;
        pc_sel   = 2'b01;
        load_pc  = 1'b1;
      end
      S_FETCH2: begin
        Mem_CE   = 1'b0;
        Mem_OE   = 1'b0;
        load_mdr = (cnt_q == WAIT_LAST);
      end
      S_FETCH3: begin
        GateMDR = 1'b1;
        load_ir = 1'b1;
      end
      S_EX_ADD, S_EX_AND: begin
        ALUK        = (state_q == S_EX_AND) ? 2'b01 : 2'b00;
        SR2_mux_sel = imm5_sel;
        GateALU     = 1'b1;
        ld_reg      = 1'b1;
      end
      S_EX_NOT: begin
        ALUK    = 2'b10;
        GateALU = 1'b1;
        ld_reg  = 1'b1;
      end
      S_EX_BR: begin
        if (BEN) begin
          pc_sel  = 2'b10;
          load_pc = 1'b1;
        end
      end
      S_EX_JMP: begin
        ALUK    = 2'b11;
        GateALU = 1'b1;
        pc_sel  = 2'b00;
        load_pc = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: instruction-level model expands each instruction into its expected per-cycle outputs.
// Build with SINGLE_STEP_EN defined to exercise the single-step states as well.
module tb_control_fsm;

  localparam int MW = 2;

  localparam logic [3:0] S_HALT = 4'd0,  S_CLR = 4'd1,  S_F1 = 4'd2,  S_F2 = 4'd3,
                         S_F3 = 4'd4,    S_DEC = 4'd5,  S_ADD = 4'd6, S_AND = 4'd7,
                         S_NOT = 4'd8,   S_BR = 4'd9,   S_JMP = 4'd10, S_P1 = 4'd11,
                         S_P2 = 4'd12;
`ifdef SINGLE_STEP_EN
  localparam logic [3:0] S_ST1 = 4'd14, S_ST2 = 4'd15;
`endif

  localparam logic [3:0] OP_ADD = 4'b0001, OP_AND = 4'b0101, OP_NOT = 4'b1001,
                         OP_BR = 4'b0000,  OP_JMP = 4'b1100, OP_PAUSE = 4'b1101;

  typedef struct packed {
    logic       load_ir, load_pc, load_mdr, load_mar, ld_reg;
    logic [1:0] pc_sel, aluk;
    logic       gate_pc, gate_mdr, gate_alu, sr2, ce, oe, we;
    logic [3:0] st;
  } outs_t;

  logic       Clk = 1'b0, Reset = 1'b0, Run = 1'b0, Continue = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       imm5_sel = 1'b0, BEN = 1'b0;
  logic       load_ir, load_pc, load_mdr, load_mar, ld_reg;
  logic [1:0] pc_sel, ALUK;
  logic       GatePC, GateMDR, GateALU, SR2_mux_sel, Mem_CE, Mem_OE, Mem_WE;
  logic [3:0] state_dbg;

  control_fsm #(.MEM_WAIT(MW), .PAUSE_OPC(OP_PAUSE)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .opcode(opcode),
    .imm5_sel(imm5_sel), .BEN(BEN), .load_ir(load_ir), .load_pc(load_pc),
    .load_mdr(load_mdr), .load_mar(load_mar), .ld_reg(ld_reg), .pc_sel(pc_sel),
    .ALUK(ALUK), .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
    .SR2_mux_sel(SR2_mux_sel), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .state_dbg(state_dbg)
  );

  always #5 Clk = ~Clk;

  int    checks = 0, fails = 0, cyc = 0, oe_low = 0, last_f1 = 0;
  outs_t exp_o;
  logic  exp_valid = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    outs_t act;
    act = {load_ir, load_pc, load_mdr, load_mar, ld_reg, pc_sel, ALUK, GatePC, GateMDR,
           GateALU, SR2_mux_sel, Mem_CE, Mem_OE, Mem_WE, state_dbg};
    if (Mem_OE === 1'b0) oe_low++;
    checks++;
    if ((int'(GatePC) + int'(GateMDR) + int'(GateALU)) > 1 || Mem_WE !== 1'b1) begin
      fails++;
      $display("FAIL bus_invariant t=%0t gates=%b%b%b we=%b required gates<=1 we=1",
               $time, GatePC, GateMDR, GateALU, Mem_WE);
    end
    if (exp_valid) begin
      checks++;
      if (act !== exp_o) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got=%h required=%h (state got %0d required %0d)",
                 $time, act, exp_o, act.st, exp_o.st);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic outs_t idle(input logic [3:0] st);
    outs_t o;
    o = '0;
    o.ce = 1'b1; o.oe = 1'b1; o.we = 1'b1;
    o.st = st;
    return o;
  endfunction

  // One clock: drive this cycle's inputs just after the edge and publish the outputs they must produce.
  task automatic tick(input logic run, input logic cont, input logic [3:0] op,
                      input logic imm, input logic ben, input outs_t e);
    @(posedge Clk);
    #1;
    Run = run; Continue = cont; opcode = op; imm5_sel = imm; BEN = ben;
    exp_o = e;
    exp_valid = 1'b1;
  endtask

  task automatic start_from_halt(input int idle_cycles);
    outs_t e;
    repeat (idle_cycles) tick(1'b0, rb(), rop(), rb(), rb(), idle(S_HALT));
    tick(1'b1, rb(), rop(), rb(), rb(), idle(S_HALT));
    e = idle(S_CLR); e.pc_sel = 2'b11; e.load_pc = 1'b1;
    tick(rb(), rb(), rop(), rb(), rb(), e);
  endtask

  task automatic f1_tick(input logic run);
    outs_t e;
    e = idle(S_F1); e.gate_pc = 1'b1; e.load_mar = 1'b1; e.pc_sel = 2'b01; e.load_pc = 1'b1;
    tick(run, rb(), rop(), rb(), rb(), e);
    last_f1 = cyc;
  endtask

  // FETCH1, then (if Run held) MW read cycles ending in load_mdr, then the IR load.
  task automatic do_fetch(input logic run);
    outs_t e;
    f1_tick(run);
    if (!run) return;
    for (int i = 0; i < MW; i++) begin
      e = idle(S_F2); e.ce = 1'b0; e.oe = 1'b0; e.load_mdr = (i == MW - 1);
      tick(rb(), rb(), rop(), rb(), rb(), e);
    end
    e = idle(S_F3); e.gate_mdr = 1'b1; e.load_ir = 1'b1;
    tick(rb(), rb(), rop(), rb(), rb(), e);
  endtask

  task automatic dec_tick(input logic [3:0] op, input logic imm, input logic ben);
    tick(rb(), rb(), op, imm, ben, idle(S_DEC));
  endtask

  task automatic exec_tick(input logic [3:0] op, input logic imm, input logic ben);
    outs_t e;
    e = idle(S_HALT);
    case (op)
      OP_ADD: begin e = idle(S_ADD); e.sr2 = imm; e.gate_alu = 1; e.ld_reg = 1; end
      OP_AND: begin e = idle(S_AND); e.aluk = 2'b01; e.sr2 = imm; e.gate_alu = 1; e.ld_reg = 1; end
      OP_NOT: begin e = idle(S_NOT); e.aluk = 2'b10; e.gate_alu = 1; e.ld_reg = 1; end
      OP_BR:  begin e = idle(S_BR); if (ben) begin e.pc_sel = 2'b10; e.load_pc = 1; end end
      OP_JMP: begin e = idle(S_JMP); e.aluk = 2'b11; e.gate_alu = 1; e.load_pc = 1; end
      default: ;
    endcase
    tick(rb(), rb(), op, imm, ben, e);
  endtask

  task automatic step_tail();
`ifdef SINGLE_STEP_EN
    repeat (3) tick(1'b1, 1'b0, rop(), rb(), rb(), idle(S_ST1));
    chk("step_hold", int'(state_dbg), int'(S_ST1));
    tick(1'b1, 1'b1, rop(), rb(), rb(), idle(S_ST1));
    tick(rb(), 1'b1, rop(), rb(), rb(), idle(S_ST2));
    tick(rb(), 1'b0, rop(), rb(), rb(), idle(S_ST2));
`endif
  endtask

  task automatic pause_seq(input int hold, input int clen);
    repeat (hold) tick(rb(), 1'b0, rop(), rb(), rb(), idle(S_P1));
    tick(rb(), 1'b1, rop(), rb(), rb(), idle(S_P1));
    repeat (clen - 1) tick(rb(), 1'b1, rop(), rb(), rb(), idle(S_P2));
    tick(rb(), 1'b0, rop(), rb(), rb(), idle(S_P2));
  endtask

  task automatic do_instr(input logic [3:0] op, input logic imm, input logic ben,
                          input int hold, input int clen);
    dec_tick(op, imm, ben);
    if (op == OP_ADD || op == OP_AND || op == OP_NOT || op == OP_BR || op == OP_JMP) begin
      exec_tick(op, imm, ben);
      step_tail();
    end else if (op == OP_PAUSE) begin
      pause_seq(hold, clen);
    end else begin
      step_tail();
    end
  endtask

  initial begin
    int t0, t_p2;
    logic in_halt;
    outs_t e;

    // Reset held low for two cycles, then released away from the edge.
    tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, idle(S_HALT));
    #1;
    chk("reset_state", int'(state_dbg), int'(S_HALT));
    chk("reset_oe", int'(Mem_OE), 1);
    tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, idle(S_HALT));
    Reset = 1'b1;

    // ADD R0,R0,#1 (0x1021): imm5 form.
    start_from_halt(2);
    oe_low = 0;
    do_fetch(1'b1);
    t0 = last_f1;
    #1;
    chk("fetch_oe_low_cycles", oe_low, 2);
    dec_tick(OP_ADD, 1'b1, rb());
    exec_tick(OP_ADD, 1'b1, rb());
    #1;
    chk("add_aluk", int'(ALUK), 0);
    chk("add_sr2", int'(SR2_mux_sel), 1);
    chk("add_gate_alu", int'(GateALU), 1);
    chk("add_ld_reg", int'(ld_reg), 1);
    step_tail();
    do_fetch(1'b1);
`ifndef SINGLE_STEP_EN
    chk("add_cycles_incl_next_fetch1", last_f1 - t0 + 1, 7);
`endif

    // BR taken, then BR not taken.
    dec_tick(OP_BR, rb(), 1'b1);
    exec_tick(OP_BR, rb(), 1'b1);
    #1;
    chk("br_taken_load_pc", int'(load_pc), 1);
    chk("br_taken_pc_sel", int'(pc_sel), 2);
    step_tail();
    do_fetch(1'b1);
    dec_tick(OP_BR, rb(), 1'b0);
    exec_tick(OP_BR, rb(), 1'b0);
    #1;
    chk("br_not_taken_load_pc", int'(load_pc), 0);
    step_tail();
    do_fetch(1'b1);

    // PAUSE: 20 idle cycles, Continue high for 3, then low releases one pause.
    dec_tick(OP_PAUSE, rb(), rb());
    repeat (20) tick(rb(), 1'b0, rop(), rb(), rb(), idle(S_P1));
    #1;
    chk("pause_hold", int'(state_dbg), int'(S_P1));
    tick(rb(), 1'b1, rop(), rb(), rb(), idle(S_P1));
    repeat (2) tick(rb(), 1'b1, rop(), rb(), rb(), idle(S_P2));
    #1;
    chk("pause_cont_held", int'(state_dbg), int'(S_P2));
    tick(rb(), 1'b0, rop(), rb(), rb(), idle(S_P2));
    t_p2 = cyc;
    do_fetch(1'b1);
    chk("pause_release_latency", last_f1 - t_p2, 1);

    // Undefined opcode acts as a NOP; Run=0 in the following FETCH1 halts.
    dec_tick(4'b1111, rb(), rb());
    step_tail();
    do_fetch(1'b0);
    tick(1'b0, rb(), rop(), rb(), rb(), idle(S_HALT));
    #1;
    chk("nop_then_halt", int'(state_dbg), int'(S_HALT));

    // Reset asserted in the middle of the first FETCH2 cycle.
    start_from_halt(0);
    f1_tick(1'b1);
    e = idle(S_F2); e.ce = 1'b0; e.oe = 1'b0;
    tick(rb(), rb(), rop(), rb(), rb(), e);
    #2;
    exp_valid = 1'b0;
    Reset = 1'b0;
    #1;
    chk("midfetch_rst_oe", int'(Mem_OE), 1);
    chk("midfetch_rst_ce", int'(Mem_CE), 1);
    chk("midfetch_rst_state", int'(state_dbg), int'(S_HALT));
    chk("midfetch_rst_mdr", int'(load_mdr), 0);
    tick(1'b0, rb(), rop(), rb(), rb(), idle(S_HALT));
    Reset = 1'b1;
    repeat (6) tick(1'b0, rb(), rop(), rb(), rb(), idle(S_HALT));

    // Randomized instruction stream with occasional halts.
    in_halt = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic       run;
      logic [3:0] op;
      int         pick;
      if (in_halt) begin
        start_from_halt($urandom_range(0, 3));
        in_halt = 1'b0;
      end
      run = ($urandom_range(0, 11) != 0);
      do_fetch(run);
      if (!run) begin
        in_halt = 1'b1;
        continue;
      end
      pick = $urandom_range(0, 6);
      case (pick)
        0: op = OP_ADD;
        1: op = OP_AND;
        2: op = OP_NOT;
        3: op = OP_BR;
        4: op = OP_JMP;
        5: op = OP_PAUSE;
        default: begin
          op = rop();
          while (op == OP_ADD || op == OP_AND || op == OP_NOT || op == OP_BR ||
                 op == OP_JMP || op == OP_PAUSE)
            op = rop();
        end
      endcase
      do_instr(op, rb(), rb(), $urandom_range(0, 5), $urandom_range(1, 3));
    end

    @(posedge Clk);
    #1;
    exp_valid = 1'b0;
    @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
